fifo2axis_pkt: RTL

Parametrised successor of the single-shot 4-word FIFO-to-AXI-Stream bridge. It buffers words from a simple write port into a circular buffer of DEPTH entries and emits them as AXI4-Stream packets of PKT_LEN beats, generating tlast itself. Writes and sends run concurrently, so back-to-back packets stream without returning to idle. It sits between the capture logic and the HLS accelerator's AXIS slave input.

---
 rtl/fifo2axis_pkg.sv | 20 ++
 rtl/fifo2axis_ring.sv | 90 +++++++++
 rtl/fifo2axis_pkt.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fifo2axis_pkg.sv
// fifo2axis_pkg
// Shared types and helpers for the fifo2axis_pkt packet bridge.
//   state_t      : packet emitter states (IDLE, SEND)
//   cnt_width()  : width of a fill counter that can hold 0..depth
//   DEFAULT_DEPTH: default number of buffer entries
package fifo2axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEFAULT_DEPTH = 16;

    // The fill count must reach DEPTH itself, hence depth+1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo2axis_ring.sv
// fifo2axis_ring
// Circular buffer of DEPTH words with write/read pointers, fill level,
// full flag and a sticky overflow flag.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   din, wr_en : write port; a write is taken only while not full
//   pop        : consume the word at the read pointer (caller guarantees level > 0)
//   rd_data    : word at the read pointer
//   full       : level == DEPTH
//   level      : current fill count
//   overflow   : set by a write attempt while full, cleared only by rst
module fifo2axis_ring
    import fifo2axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic [CNT_W-1:0]      level,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_accept;

    assign full      = (level_q == CNT_W'(DEPTH));
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign rd_data   = mem_q[rd_ptr_q];

    // full is judged on the registered level, so a write that coincides
    // with a pop on a full buffer is still rejected.
    assign wr_accept = wr_en && !full;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q || (wr_en && full);

        if (wr_accept) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_accept, pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage itself carries no reset; only pointers and level decide validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/fifo2axis_pkt.sv
// fifo2axis_pkt
// Buffers words from a simple write port and emits them as AXI4-Stream
// packets of PKT_LEN beats, generating tlast. Back-to-back packets stream
// without returning to IDLE.
// Optional feature macro: FIFO2AXIS_FLUSH_EN adds a 'flush' input that sends
// a short packet made of whatever is buffered (fewer than PKT_LEN words).
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : (FIFO2AXIS_FLUSH_EN only) request a short packet
//   din, wr_en       : write port
//   full, level      : buffer status
//   enable           : arm packet emission
//   m_axis_*         : AXI4-Stream master (tdata, tvalid, tready, tlast)
//   start_accel      : held high whenever out of reset
//   pkt_done         : one-cycle pulse after the tlast beat handshakes
//   overflow         : sticky write-while-full flag
module fifo2axis_pkt
    import fifo2axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int PKT_LEN    = 4,
    parameter int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef FIFO2AXIS_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic [CNT_W-1:0]      level,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  start_accel,
    output logic                  pkt_done,
    output logic                  overflow
);

    localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [CNT_W-1:0]      beat_idx;
    logic [CNT_W-1:0]      pkt_target;
    logic [CNT_W-1:0]      tgt_len;
    logic                  pkt_ready;

`ifdef FIFO2AXIS_FLUSH_EN
    logic [CNT_W-1:0]      tgt_len_q, tgt_len_d;
    logic                  flush_pend_q, flush_pend_d;
    assign tgt_len = tgt_len_q;
`else
    assign tgt_len = PKT_LEN_C;
`endif

    fifo2axis_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .wr_en    (wr_en),
        .pop      (pop),
        .rd_data  (rd_data),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign pkt_done      = pkt_done_q;
    assign start_accel   = !rst;

    assign pkt_ready = enable && (level >= PKT_LEN_C);

    // Packet FSM, beat counter and output register. A pop always loads the
    // output register; once the tlast beat is loaded no further pop happens
    // until it handshakes, at which point the next packet may start in the
    // same cycle so back-to-back packets have no bubble.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        pkt_done_d = tvalid_q && m_axis_tready && tlast_q;
        pop        = 1'b0;
        beat_idx   = beat_cnt_q;
        pkt_target = tgt_len;
`ifdef FIFO2AXIS_FLUSH_EN
        tgt_len_d    = tgt_len_q;
        flush_pend_d = flush_pend_q || flush;
`endif

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
`ifdef FIFO2AXIS_FLUSH_EN
                // A flush seen here is either acted on now or dropped (empty buffer).
                flush_pend_d = 1'b0;
`endif
                if (pkt_ready) begin
                    state_d    = SEND;
                    beat_cnt_d = '0;
`ifdef FIFO2AXIS_FLUSH_EN
                    tgt_len_d  = PKT_LEN_C;
                end else if ((flush || flush_pend_q) && (level != '0)) begin
                    state_d    = SEND;
                    beat_cnt_d = '0;
                    tgt_len_d  = (level < PKT_LEN_C) ? level : PKT_LEN_C;
`endif
                end
            end
            SEND: begin
                if (tvalid_q && tlast_q) begin
                    if (m_axis_tready) begin
                        if (pkt_ready) begin
                            pop        = 1'b1;
                            beat_idx   = '0;
                            pkt_target = PKT_LEN_C;
`ifdef FIFO2AXIS_FLUSH_EN
                            tgt_len_d  = PKT_LEN_C;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if ((!tvalid_q || m_axis_tready) && (level != '0)) begin
                    pop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            tdata_d    = rd_data;
            tvalid_d   = 1'b1;
            tlast_d    = (beat_idx == pkt_target - CNT_W'(1));
            beat_cnt_d = beat_idx + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            pkt_done_q   <= 1'b0;
`ifdef FIFO2AXIS_FLUSH_EN
            tgt_len_q    <= PKT_LEN_C;
            flush_pend_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            pkt_done_q   <= pkt_done_d;
`ifdef FIFO2AXIS_FLUSH_EN
            tgt_len_q    <= tgt_len_d;
            flush_pend_q <= flush_pend_d;
`endif
        end
    end

endmodule
